// File: rtl/seg_scan_bcd.sv
// Purpose: binary to BCD conversion (sequential double-dabble) feeding a multiplexed 7-segment scanner.
// Latency: a load accepted in IDLE updates the display buffer BIN_W+1 cycles later. Scan outputs change only on prescaler ticks.
// Backpressure: busy=1 while converting, and any load seen during that time is dropped (not queued).
// Ports:
//   inclk0    system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      capture request for bin, honoured only in IDLE
//   bin       unsigned value to display
//   blank_lz  1 = blank leading zeros
//   dp_mask   per-digit decimal point enable, bit DIGITS-1 = MSD
//   busy      conversion in progress
//   ovf       committed value did not fit in DIGITS decimal digits
//   SEG       one-hot digit select, bit DIGITS-1 = MSD
//   codeout   segments {g,f,e,d,c,b,a}, 1 = lit
//   dp        decimal point of the selected digit
module seg_scan_bcd #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              inclk0,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BIN_W-1:0]  bin,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] SEG,
  output logic [6:0]        codeout,
  output logic              dp
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = $clog2(DIGITS);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0]       LIMIT   = pow10(DIGITS);
  localparam logic [DIGITS-1:0] MSB_SEL = {1'b1, {(DIGITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t           state;
  logic [BIN_W-1:0] sh;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] disp;
  logic             ovf_cap;
  logic [CW-1:0]    cnt;

  // add-3 correction applied to every nibble before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      ovf_cap <= 1'b0;
      sh      <= '0;
      bcd     <= '0;
      disp    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sh      <= bin;
            bcd     <= '0;
            ovf_cap <= (32'(bin) >= LIMIT);
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          // bits shifted out of the top nibble are lost; ovf_cap accounts for that
          bcd <= {bcd_adj[BCD_W-2:0], sh[BIN_W-1]};
          sh  <= {sh[BIN_W-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(BIN_W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          disp  <= bcd;
          ovf   <= ovf_cap;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------- display scan ----------------
  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;      // digit shown at the next tick, 0 = MSD
  logic              tick;
  logic              is_lsd;
  logic              lead_zero;
  logic [3:0]        cur_nib;
  logic [6:0]        seg7;
  logic [6:0]        code_nxt;
  logic [DIGITS-1:0] seg_nxt;

  assign tick   = (presc == PW'(SCAN_DIV - 1));
  assign is_lsd = (idx == IW'(DIGITS - 1));

  always_comb begin
    cur_nib   = 4'd0;
    lead_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx) cur_nib = disp[4*(DIGITS-1-j) +: 4];
      // any nonzero digit at or above the selected one ends the leading-zero run
      if (IW'(j) <= idx && disp[4*(DIGITS-1-j) +: 4] != 4'd0) lead_zero = 1'b0;
    end
    case (cur_nib)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
    if (ovf)                               code_nxt = 7'b1000000;
    else if (blank_lz && lead_zero && !is_lsd) code_nxt = 7'b0000000;
    else                                   code_nxt = seg7;
    seg_nxt = MSB_SEL >> idx;
  end

  always_ff @(posedge inclk0 or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      SEG     <= '0;
      codeout <= '0;
      dp      <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        SEG     <= seg_nxt;
        codeout <= code_nxt;
        dp      <= ovf ? 1'b0 : |(dp_mask & seg_nxt);
        idx     <= is_lsd ? '0 : idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Purpose: self-checking bench for seg_scan_bcd with DIGITS=4, BIN_W=14, SCAN_DIV=4.
// Expected display is computed from decimal arithmetic on the loaded value, not from BCD hardware steps.
// Ports: none (top-level bench).
module tb_seg_scan_bcd;

  logic       inclk0;
  logic       rst_n;
  logic       load;
  logic [13:0] bin;
  logic       blank_lz;
  logic [3:0] dp_mask;
  logic       busy;
  logic       ovf;
  logic [3:0] SEG;
  logic [6:0] codeout;
  logic       dp;

  int checks = 0;
  int errors = 0;

  int         p10 [4]     = '{1000, 100, 10, 1};
  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  seg_scan_bcd #(.DIGITS(4), .BIN_W(14), .SCAN_DIV(4)) dut (
    .inclk0   (inclk0),
    .rst_n    (rst_n),
    .load     (load),
    .bin      (bin),
    .blank_lz (blank_lz),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .ovf      (ovf),
    .SEG      (SEG),
    .codeout  (codeout),
    .dp       (dp)
  );

  initial inclk0 = 1'b0;
  always #5 inclk0 = ~inclk0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // reference: digit k (0 = MSD) of value v as displayed
  function automatic logic [6:0] exp_code(input int v, input int k, input logic blk);
    int upper;
    if (v >= 10000) return 7'b1000000;
    upper = v / p10[k];
    if (blk && upper == 0 && k != 3) return 7'b0000000;
    return seg_tab[upper % 10];
  endfunction

  // load v1; at busy-cycle 'at' drive a competing load of v2; n = busy cycles seen
  task automatic conv(input int v1, input int v2, input int at, output int n);
    @(negedge inclk0);
    load = 1'b1;
    bin  = 14'(v1);
    @(negedge inclk0);
    load = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == at) begin
        load = 1'b1;
        bin  = 14'(v2);
      end else begin
        load = 1'b0;
      end
      @(negedge inclk0);
    end
    load = 1'b0;
  endtask

  // observe one full scan starting at the MSD and compare with the model
  task automatic scan_check(input string tag, input int v, input logic blk, input logic [3:0] dpm);
    int t;
    logic [3:0] seg_exp;
    blank_lz = blk;
    dp_mask  = dpm;
    t = 0;
    while (SEG == 4'b1000 && t < 50) begin t++; @(negedge inclk0); end
    t = 0;
    while (SEG != 4'b1000 && t < 50) begin t++; @(negedge inclk0); end
    check({tag, " scan_sync"}, 32'(t < 50), 32'd1);
    for (int k = 0; k < 4; k++) begin
      seg_exp = 4'(1 << (3 - k));
      check($sformatf("%s seg[%0d]", tag, k), 32'(SEG), 32'(seg_exp));
      check($sformatf("%s code[%0d]", tag, k), 32'(codeout), 32'(exp_code(v, k, blk)));
      check($sformatf("%s dp[%0d]", tag, k), 32'(dp), 32'((v >= 10000) ? 1'b0 : dpm[3-k]));
      repeat (3) @(negedge inclk0);
      check($sformatf("%s hold[%0d]", tag, k), 32'(SEG), 32'(seg_exp));
      @(negedge inclk0);
    end
  endtask

  initial begin
    int n;
    int v;
    logic       rb;
    logic [3:0] rm;

    rst_n    = 1'b1;
    load     = 1'b0;
    bin      = '0;
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
    #1 rst_n = 1'b0;

    // reset state
    @(negedge inclk0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst seg", 32'(SEG), 32'd0);
    check("rst code", 32'(codeout), 32'd0);
    check("rst dp", 32'(dp), 32'd0);
    rst_n = 1'b1;

    // nothing changes until SCAN_DIV cycles after release, then digit 0
    for (int i = 1; i <= 3; i++) begin
      @(negedge inclk0);
      check($sformatf("pre-tick seg %0d", i), 32'(SEG), 32'd0);
      check($sformatf("pre-tick code %0d", i), 32'(codeout), 32'd0);
      check($sformatf("pre-tick busy %0d", i), 32'(busy), 32'd0);
    end
    @(negedge inclk0);
    check("first tick seg", 32'(SEG), 32'b1000);
    check("first tick code", 32'(codeout), 32'(exp_code(0, 0, 1'b0)));

    // 1234
    conv(1234, 0, 0, n);
    check("1234 busy cycles", 32'(n), 32'd15);
    check("1234 ovf", 32'(ovf), 32'd0);
    scan_check("1234", 1234, 1'b0, 4'b0000);

    // 7 with blanking and dp, then without blanking
    conv(7, 0, 0, n);
    check("7 busy cycles", 32'(n), 32'd15);
    scan_check("7 blank", 7, 1'b1, 4'b0100);
    scan_check("7 noblank", 7, 1'b0, 4'b0100);

    // overflow, then back in range
    conv(10000, 0, 0, n);
    check("10000 busy cycles", 32'(n), 32'd15);
    check("10000 ovf", 32'(ovf), 32'd1);
    scan_check("10000", 10000, 1'b1, 4'b1111);
    conv(9999, 0, 0, n);
    check("9999 ovf", 32'(ovf), 32'd0);
    scan_check("9999", 9999, 1'b0, 4'b0000);

    // load during conversion is dropped
    conv(1234, 5678, 3, n);
    check("ignored load busy cycles", 32'(n), 32'd15);
    @(negedge inclk0);
    check("ignored load stays idle", 32'(busy), 32'd0);
    scan_check("ignored load", 1234, 1'b0, 4'b0000);

    // load in the COMMIT cycle is dropped
    conv(4321, 8765, 15, n);
    check("commit load busy cycles", 32'(n), 32'd15);
    @(negedge inclk0);
    check("commit load stays idle", 32'(busy), 32'd0);
    scan_check("commit load", 4321, 1'b0, 4'b1010);

    // randomized values
    for (int r = 0; r < 6; r++) begin
      v  = int'($urandom_range(0, 16383));
      rb = 1'($urandom_range(0, 1));
      rm = 4'($urandom_range(0, 15));
      conv(v, 0, 0, n);
      check($sformatf("rand%0d busy cycles", r), 32'(n), 32'd15);
      check($sformatf("rand%0d ovf", r), 32'(ovf), 32'(v >= 10000));
      scan_check($sformatf("rand%0d v=%0d", r, v), v, rb, rm);
    end

    // reset in the middle of converting 4321
    @(negedge inclk0);
    load = 1'b1;
    bin  = 14'd4321;
    @(negedge inclk0);
    load = 1'b0;
    repeat (4) @(negedge inclk0);
    check("midrst busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    check("midrst seg", 32'(SEG), 32'd0);
    check("midrst code", 32'(codeout), 32'd0);
    @(negedge inclk0);
    rst_n = 1'b1;
    scan_check("after midrst", 0, 1'b1, 4'b0000);
    check("after midrst busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_bcd.md
SEG_SCAN_BCD -- requirements
Module: seg_scan_bcd

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of scanned 7-segment digits (legal 2..8).
REQ-002 SHALL have parameter BIN_W, default 14, width of the binary input value (legal 4..27).
REQ-003 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit dwell (legal >= 2).
REQ-004 SHALL have port inclk0  input  1  single system clock, rising-edge active.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load  input  1  request to capture bin, sampled each clock.
REQ-007 SHALL have port bin  input  BIN_W  unsigned value to display.
REQ-008 SHALL have port blank_lz  input  1  1 = blank leading zeros.
REQ-009 SHALL have port dp_mask  input  DIGITS  decimal-point enable per digit; bit DIGITS-1 = most significant digit.
REQ-010 SHALL have port busy  output  1  conversion in progress.
REQ-011 SHALL have port ovf  output  1  last committed value was >= 10^DIGITS.
REQ-012 SHALL have port SEG  output  DIGITS  one-hot digit select, active-high; bit DIGITS-1 = most significant digit.
REQ-013 SHALL have port codeout  output  7  segment pattern {g,f,e,d,c,b,a}, 1 = lit.
REQ-014 SHALL have port dp  output  1  decimal point of the currently selected digit.

Function
REQ-015 FSM SHALL have states IDLE, CONV, COMMIT; reset state IDLE.
REQ-016 In IDLE with load=1, SHALL capture bin and a comparison flag (bin >= 10^DIGITS) and enter CONV next cycle.
REQ-017 CONV SHALL perform sequential double-dabble: one shift per cycle, add-3 to every BCD nibble >= 5 before each shift, exactly BIN_W cycles.
REQ-018 COMMIT SHALL last 1 cycle, copy BCD result and overflow flag into the display buffer and ovf, then return to IDLE.
REQ-019 busy SHALL be 1 in CONV and COMMIT, 0 in IDLE; display buffer updates at the end of cycle BIN_W+1 after load is accepted.
REQ-020 load asserted while busy=1 SHALL be ignored (no queuing); load in the same cycle as COMMIT is also ignored.
REQ-021 Display buffer SHALL hold the previous value throughout a conversion (no partial digits shown).
REQ-022 BCD register SHALL be 4*DIGITS bits; higher-order digits beyond DIGITS are discarded, ovf covers the loss.
REQ-023 Prescaler SHALL count 0..SCAN_DIV-1 and wrap, issuing a one-cycle tick on the terminal count.
REQ-024 Digit index SHALL advance on each tick, 0..DIGITS-1 then wrap to 0; index 0 = most significant digit.
REQ-025 On each tick SHALL register SEG (one-hot for the new index), codeout and dp together; no output change between ticks.
REQ-026 Digit codes 0-9 SHALL use standard patterns (0=0111111, 1=0000110, 4=1100110, 7=0000111, 9=1101111).
REQ-027 When ovf=1, every digit SHALL show dash 1000000 and dp SHALL be 0.
REQ-028 When blank_lz=1 and ovf=0, digits more significant than the first nonzero digit SHALL show 0000000; least significant digit is never blanked.
REQ-029 dp SHALL equal dp_mask bit of the selected digit, sampled at the tick, also on blanked digits.

Reset
REQ-030 rst_n=0 SHALL immediately force: FSM IDLE, busy=0, ovf=0, prescaler=0, digit index=0, display buffer=0, SEG=0, codeout=0, dp=0.
REQ-031 Reset mid-conversion SHALL abort it; captured value is discarded and the display buffer stays 0.
REQ-032 After release, first tick SHALL occur SCAN_DIV cycles later and select digit 0.

Verification (DIGITS=4, BIN_W=14, SCAN_DIV=4)
REQ-033 Reset asserted then released -> SEG=0000, codeout=0000000, busy=0 until first tick; then SEG=1000.
REQ-034 load with bin=1234 -> busy=1 for 15 cycles; scan shows SEG 1000/0100/0010/0001 with codeout 0000110/1011011/1001111/1100110.
REQ-035 bin=7, blank_lz=1, dp_mask=0100 -> digits blank, blank(dp=1), blank, 0000111; blank_lz=0 -> 0111111,0111111,0111111,0000111.
REQ-036 bin=10000 -> ovf=1, all four digits 1000000, dp=0; subsequent bin=9999 -> ovf=0, all 1101111.
REQ-037 load bin=1234, then load bin=9999 three cycles later -> second load ignored, display 1234, busy drops after 15 cycles.
REQ-038 rst_n pulsed low at cycle 5 of a conversion of bin=4321 -> busy=0 at once, display reverts to 0 (LSD 0111111 with blank_lz=1).
